// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue: instruction fetch with DEPTH-entry prefetch queue, credit-    |
// | based request/grant toward memory and valid/ready toward decode.          |
// | Optional FETCH_BYPASS_EN: empty-queue responses go straight to decode.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_queue #(
   parameter int          ADDR_W   = 16,
   parameter int          DATA_W   = 16,
   parameter int          DEPTH    = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] target_bp,
   input  logic              target_en_bp,
   output logic              mem_req,
   output logic [ADDR_W-1:0] address_to_memory,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] data_from_memory,
   output logic [DATA_W-1:0] instruction_if,
   output logic [ADDR_W-1:0] next_program_counter_if,
   output logic              if_valid,
   input  logic              if_ready
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_rsp_pc;
   logic [c_CNT_W-1:0] r_out;
   logic [c_CNT_W-1:0] r_discard;
   logic [c_CNT_W-1:0] r_count;
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W-1:0] r_rptr;
   logic [DATA_W-1:0]  r_data [DEPTH];
   logic [ADDR_W-1:0]  r_npc  [DEPTH];

   logic               w_credit;
   logic               w_gnt;
   logic               w_rsp;
   logic               w_keep;
   logic               w_q_valid;
   logic               w_byp;
   logic               w_pop;
   logic               w_push;
   logic [c_CNT_W-1:0] w_out_nxt;
   logic [ADDR_W-1:0]  w_rsp_npc;

   assign w_credit  = ({1'b0, r_count} + {1'b0, r_out}) < (c_CNT_W + 1)'(DEPTH);
   assign mem_req   = !rst && !target_en_bp && w_credit;
   assign w_gnt     = mem_req && mem_gnt;
   // Responses with nothing outstanding are stale (e.g. issued before reset).
   assign w_rsp     = mem_rvalid && (r_out != '0);
   assign w_keep    = w_rsp && (r_discard == '0) && !target_en_bp;
   assign w_q_valid = (r_count != '0);
   assign w_rsp_npc = r_rsp_pc + ADDR_W'(1);
   assign address_to_memory = r_pc;

`ifdef FETCH_BYPASS_EN
   assign w_byp = w_keep && !w_q_valid;
`else
   assign w_byp = 1'b0;
`endif

   assign if_valid = !target_en_bp && (w_q_valid || w_byp);
   assign w_pop    = if_valid && if_ready && w_q_valid;
   assign w_push   = w_keep && !(w_byp && if_ready);

   always_comb begin
      instruction_if          = '0;
      next_program_counter_if = '0;
      if (w_q_valid) begin
         instruction_if          = r_data[r_rptr];
         next_program_counter_if = r_npc[r_rptr];
      end else if (w_byp) begin
         instruction_if          = data_from_memory;
         next_program_counter_if = w_rsp_npc;
      end
   end

   always_comb begin
      w_out_nxt = r_out;
      if (w_gnt && !w_rsp)
         w_out_nxt = r_out + c_CNT_W'(1);
      else if (!w_gnt && w_rsp)
         w_out_nxt = r_out - c_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= ADDR_W'(RESET_PC);
         r_rsp_pc  <= ADDR_W'(RESET_PC);
         r_out     <= '0;
         r_discard <= '0;
         r_count   <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
      end else begin
         r_out <= w_out_nxt;
         if (target_en_bp) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_pc      <= target_bp;
            r_rsp_pc  <= target_bp;
            r_discard <= w_out_nxt;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
         end else begin
            if (w_gnt)
               r_pc <= r_pc + ADDR_W'(1);
            if (w_rsp && (r_discard != '0))
               r_discard <= r_discard - c_CNT_W'(1);
            if (w_keep)
               r_rsp_pc <= w_rsp_npc;
            if (w_push)
               r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)
               r_rptr <= r_rptr + c_PTR_W'(1);
            if (w_push && !w_pop)
               r_count <= r_count + c_CNT_W'(1);
            else if (!w_push && w_pop)
               r_count <= r_count - c_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !target_en_bp) begin
         r_data[r_wptr] <= data_from_memory;
         r_npc[r_wptr]  <= w_rsp_npc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_queue: randomized fetch traffic against a queue-based model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

   localparam int          AW     = 16;
   localparam int          DW     = 16;
   localparam int          DEPTH  = 4;
   localparam int unsigned RST_PC = 0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] target_bp = '0;
   logic          target_en_bp = 1'b0;
   logic          mem_req;
   logic [AW-1:0] address_to_memory;
   logic          mem_gnt = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] data_from_memory = '0;
   logic [DW-1:0] instruction_if;
   logic [AW-1:0] next_program_counter_if;
   logic          if_valid;
   logic          if_ready = 1'b0;

   fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .target_bp               (target_bp),
      .target_en_bp            (target_en_bp),
      .mem_req                 (mem_req),
      .address_to_memory       (address_to_memory),
      .mem_gnt                 (mem_gnt),
      .mem_rvalid              (mem_rvalid),
      .data_from_memory        (data_from_memory),
      .instruction_if          (instruction_if),
      .next_program_counter_if (next_program_counter_if),
      .if_valid                (if_valid),
      .if_ready                (if_ready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [DW-1:0] data; logic [AW-1:0] npc; } word_t;
   typedef struct { logic [AW-1:0] addr; logic live; } fl_t;
   typedef struct { logic [AW-1:0] addr; int due; } rsp_t;

   word_t exp_q[$];  // words decode should still receive, in order
   fl_t   fl_q[$];   // granted requests the fetch unit still counts as outstanding
   rsp_t  rsp_q[$];  // memory-side pending responses (may outlive a reset)
   logic [AW-1:0] m_pc;
   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int gnt_pct = 100, rsp_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
   logic hold_gnt = 1'b0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 16'd40503) ^ 16'h5A3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic run_cycle(input logic redir, input logic [AW-1:0] tgt);
      logic rv, rdy, exp_req, live_rsp, bypass, exp_valid, taken;
      word_t hd;
      fl_t   ent;
      rdy = ($urandom_range(99) < rdy_pct);
      rv  = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
      target_en_bp     = redir;
      target_bp        = tgt;
      if_ready         = rdy;
      mem_gnt          = !hold_gnt && ($urandom_range(99) < gnt_pct);
      mem_rvalid       = rv;
      data_from_memory = rv ? mem_word(rsp_q[0].addr) : DW'($urandom);
      #4;
      exp_req  = !redir && (exp_q.size() + fl_q.size() < DEPTH);
      live_rsp = rv && (fl_q.size() > 0) && fl_q[0].live;
      bypass   = 1'b0;
`ifdef FETCH_BYPASS_EN
      bypass = !redir && live_rsp && (exp_q.size() == 0);
`endif
      exp_valid = !redir && ((exp_q.size() > 0) || bypass);
      if (exp_q.size() > 0)
         hd = exp_q[0];
      else if (bypass) begin
         hd.data = mem_word(fl_q[0].addr);
         hd.npc  = fl_q[0].addr + AW'(1);
      end
      check("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req)
         check("address_to_memory", 32'(address_to_memory), 32'(m_pc));
      check("if_valid", 32'(if_valid), 32'(exp_valid));
      if (exp_valid) begin
         check("instruction_if", 32'(instruction_if), 32'(hd.data));
         check("next_pc_if", 32'(next_program_counter_if), 32'(hd.npc));
      end
      taken = exp_valid && rdy;
      if (taken && exp_q.size() > 0)
         void'(exp_q.pop_front());
      if (redir) begin
         m_pc = tgt;
         exp_q.delete();
         foreach (fl_q[i]) fl_q[i].live = 1'b0;
      end
      if (rv) begin
         void'(rsp_q.pop_front());
         if (fl_q.size() > 0) begin
            ent = fl_q.pop_front();
            if (ent.live && !redir && !(bypass && taken))
               exp_q.push_back('{data: mem_word(ent.addr), npc: ent.addr + AW'(1)});
         end
      end
      if (exp_req && mem_gnt) begin
         fl_q.push_back('{addr: m_pc, live: 1'b1});
         rsp_q.push_back('{addr: m_pc, due: cyc + $urandom_range(lat_max, lat_min)});
         m_pc = m_pc + AW'(1);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle(1'b0, '0);
   endtask

   initial begin
      m_pc = AW'(RST_PC);
      #2;
      check("reset if_valid", 32'(if_valid), 32'd0);
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset instruction_if", 32'(instruction_if), 32'd0);
      check("reset next_pc_if", 32'(next_program_counter_if), 32'd0);
      check("reset address", 32'(address_to_memory), 32'(RST_PC));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Steady stream, one-cycle memory, decode always ready.
      run_n(30);

      // Decode stalls, queue fills, then drains.
      rdy_pct = 0;
      run_n(10);
      check("stall queue full", 32'(exp_q.size()), 32'(DEPTH));
      rdy_pct = 100;
      run_n(10);

      // Redirect with slow memory so older responses are still in flight.
      lat_min = 3; lat_max = 3;
      run_n(3);
      run_cycle(1'b1, 16'h0040);
      run_n(12);

      // PC wraps past the top of the address space.
      lat_min = 1; lat_max = 1;
      run_cycle(1'b1, 16'hFFFE);
      run_n(10);

      // Redirect coinciding with a response, then a second redirect.
      run_n(3);
      run_cycle(1'b1, 16'h0080);
      run_cycle(1'b1, 16'h0090);
      run_n(12);

      // Random traffic with occasional (sometimes back-to-back) redirects.
      gnt_pct = 70; rsp_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 4;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(99) < 6)
            run_cycle(1'b1, AW'($urandom));
         else
            run_cycle(1'b0, '0);
      end

      // Reset mid-burst with a full queue and requests in flight.
      gnt_pct = 100; rsp_pct = 100; rdy_pct = 0; lat_min = 3; lat_max = 4;
      run_n(6);
      rst = 1'b1;
      target_en_bp = 1'b0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      #2;
      check("midrst if_valid", 32'(if_valid), 32'd0);
      check("midrst mem_req", 32'(mem_req), 32'd0);
      check("midrst instruction_if", 32'(instruction_if), 32'd0);
      check("midrst next_pc_if", 32'(next_program_counter_if), 32'd0);
      exp_q.delete();
      fl_q.delete();
      m_pc = AW'(RST_PC);
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold_gnt = 1'b1;
      rdy_pct = 100;
      for (int i = 0; i < 20 && rsp_q.size() > 0; i++) run_cycle(1'b0, '0);
      hold_gnt = 1'b0;
      lat_min = 1; lat_max = 2;
      run_n(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
